// File: rtl/mb8_arbiter.sv
// Round-robin arbiter sharing one synchronous 8-bit memory port between NREQ masters, with per-master lock.
// Optional lock watchdog enabled by defining ARB_WDOG_EN (adds the wdog_err output).
module mb8_arbiter #(
  parameter int NREQ = 3,
  parameter int ASZ  = 17,
  parameter int DSZ  = 8,
  parameter int MAXB = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ-1:0]     we,
  input  logic [NREQ*ASZ-1:0] ai,
  input  logic [NREQ*DSZ-1:0] vi,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     vld,
  output logic [DSZ-1:0]      vo,
  output logic                mb_we,
  output logic [ASZ-1:0]      mb_ai,
  output logic [DSZ-1:0]      mb_vi,
  input  logic [DSZ-1:0]      mb_vo,
  output logic                busy
`ifdef ARB_WDOG_EN
  ,
  output logic                wdog_err
`endif
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_rr;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_vld;

  logic [ASZ-1:0]  w_ai_arr [NREQ];
  logic [DSZ-1:0]  w_vi_arr [NREQ];
  logic [NREQ-1:0] w_own_mask;
  logic [IW-1:0]   w_succ;
  logic [IW:0]     w_pick_idle;
  logic [IW:0]     w_pick_next;
  logic            w_st_own;
  logic            w_own_req;
  logic            w_own_lock;
  logic            w_others;
  logic            w_release;
  logic            w_preempt;
  logic            w_leave;
  logic            w_fire;

  if (NREQ < 2 || NREQ > 8 || MAXB < 1) begin : g_bad_param
    $error("mb8_arbiter: NREQ must be 2..8 and MAXB at least 1");
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_ai_arr[gi] = ai[gi*ASZ +: ASZ];
    assign w_vi_arr[gi] = vi[gi*DSZ +: DSZ];
  end

  // Returns {found, index} of the first set bit of mask at or after start, wrapping.
  function automatic logic [IW:0] f_pick(input logic [NREQ-1:0] mask, input logic [IW-1:0] start);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(start) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (mask[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  assign w_st_own    = (r_state == ST_OWN);
  assign w_own_mask  = NREQ'(1) << r_owner;
  assign w_succ      = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_own_req   = req[r_owner];
  assign w_own_lock  = lock[r_owner];
  assign w_others    = |(req & ~w_own_mask);
  assign w_pick_idle = f_pick(req, r_rr);
  assign w_pick_next = f_pick(req & ~w_own_mask, w_succ);

  assign w_release = w_st_own & ~w_own_req;
  assign w_preempt = w_st_own & w_own_req & w_others & (~w_own_lock | w_fire);
  assign w_leave   = w_release | w_preempt;

`ifdef ARB_WDOG_EN
  localparam int CW = $clog2(MAXB + 1);

  logic [CW-1:0] r_wcnt;
  logic          r_wdog_err;
  logic          w_hold;

  assign w_hold = w_st_own & w_own_req & w_own_lock & w_others;
  // A forced preemption waits out a write so the grant never moves under mb_we with lock held.
  assign w_fire = w_hold & (r_wcnt >= CW'(MAXB - 1)) & ~mb_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt     <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_err <= w_fire;
      if (w_leave || !w_hold)
        r_wcnt <= '0;
      else if (r_wcnt < CW'(MAXB - 1))
        r_wcnt <= r_wcnt + 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_vld   <= '0;
    end else begin
      r_vld <= r_gnt & req & ~we;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_OWN;
            r_owner <= w_pick_idle[IW-1:0];
            r_gnt   <= NREQ'(1) << w_pick_idle[IW-1:0];
          end
        end
        ST_OWN: begin
          if (w_leave) begin
            r_rr <= w_succ;
            // Hand over directly to the next pending master so there is no idle cycle.
            if (w_pick_next[IW]) begin
              r_owner <= w_pick_next[IW-1:0];
              r_gnt   <= NREQ'(1) << w_pick_next[IW-1:0];
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign mb_ai = w_st_own ? w_ai_arr[r_owner] : '0;
  assign mb_vi = w_st_own ? w_vi_arr[r_owner] : '0;
  assign mb_we = |(we & req & r_gnt);
  assign gnt   = r_gnt;
  assign vld   = r_vld;
  assign vo    = mb_vo;
  assign busy  = |r_gnt;

endmodule
